// File: rtl/sap_prog_mem.sv
// sap_prog_mem: run-time loadable program/data memory for the SAP datapath.
//
// After reset an INIT sequence zeroes every word (one word per clock), then the
// block enters RUN (reads allowed) or PROG (writes allowed) depending on PROG.
//
// Ports:
//   CLK        system clock, rising edge
//   CLR_       asynchronous active-low reset
//   address    read address from MAR
//   CE_        active-low chip enable / W-bus drive
//   MEM_Out    tri-state W-bus output, driven only in RUN with CE_=0
//   ready      high in RUN
//   PROG       program-mode request
//   prog_auto  1 = write at wr_ptr, 0 = write at prog_addr
//   prog_addr  explicit write address
//   prog_data  write data
//   wr_valid   write request
//   wr_ready   high in PROG
//   wr_ptr     auto-increment write pointer
//   wr_wrap    sticky: wr_ptr wrapped past DEPTH-1
//   parity_err (SAP_MEM_PARITY_EN only) read parity mismatch, aligned with data
//
// Optional feature macro: SAP_MEM_PARITY_EN adds an even-parity bit per word.
module sap_prog_mem #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              CLK,
  input  logic              CLR_,
  input  logic [ADDR_W-1:0] address,
  input  logic              CE_,
  output logic [DATA_W-1:0] MEM_Out,
  output logic              ready,
  input  logic              PROG,
  input  logic              prog_auto,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              wr_wrap
`ifdef SAP_MEM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

`ifdef SAP_MEM_PARITY_EN
  localparam int unsigned WORD_W = DATA_W + 1;
`else
  localparam int unsigned WORD_W = DATA_W;
`endif

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_PROG
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [DATA_W-1:0]   data_q;
  logic [WORD_W-1:0]   mem [DEPTH];

  logic [ADDR_W-1:0]   wr_addr;
  logic                wr_fire;
  logic                rd_fire;
  logic                rd_in_range;
  logic                wr_in_range;
  logic [WORD_W-1:0]   wr_word;

  always_comb begin
    wr_addr     = prog_auto ? wr_ptr : prog_addr;
    wr_fire     = (state == ST_PROG) && wr_valid;
    rd_fire     = (state == ST_RUN) && !CE_;
    rd_in_range = {1'b0, address} < DEPTH_L;
    wr_in_range = {1'b0, wr_addr} < DEPTH_L;
`ifdef SAP_MEM_PARITY_EN
    // Even parity: stored word (data + parity bit) always has an even popcount.
    wr_word     = {^prog_data, prog_data};
`else
    wr_word     = prog_data;
`endif
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    wr_ready  = 1'b0;
    case (state)
      ST_INIT: begin
        if (clr_cnt == LAST) state_nxt = PROG ? ST_PROG : ST_RUN;
      end
      ST_RUN: begin
        ready = 1'b1;
        if (PROG) state_nxt = ST_PROG;
      end
      ST_PROG: begin
        wr_ready = 1'b1;
        if (!PROG) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_) begin
    if (!CLR_) begin
      state   <= ST_INIT;
      clr_cnt <= '0;
      data_q  <= '0;
      wr_ptr  <= '0;
      wr_wrap <= 1'b0;
`ifdef SAP_MEM_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == ST_INIT && clr_cnt != LAST) clr_cnt <= clr_cnt + 1'b1;

      // A fresh programming session from RUN restarts the pointer and wrap flag.
      if (state == ST_RUN && PROG) begin
        wr_ptr  <= '0;
        wr_wrap <= 1'b0;
      end else if (wr_fire && prog_auto) begin
        if (wr_ptr == LAST) begin
          wr_ptr  <= '0;
          wr_wrap <= 1'b1;
        end else begin
          wr_ptr  <= wr_ptr + 1'b1;
        end
      end

      if (rd_fire) data_q <= rd_in_range ? mem[address][DATA_W-1:0] : '0;
`ifdef SAP_MEM_PARITY_EN
      parity_err <= rd_fire && rd_in_range && (^mem[address]);
`endif
    end
  end

  // Storage has no reset; INIT zeroes it word by word.
  always_ff @(posedge CLK) begin
    if (state == ST_INIT)
      mem[clr_cnt] <= '0;
    else if (wr_fire && wr_in_range)
      mem[wr_addr] <= wr_word;
  end

  assign MEM_Out = rd_fire ? data_q : 'z;

endmodule
